seq_count_sched: RTL
====================

# seq_count_sched

Round-robin scheduler that time-shares a single binary up-counter among `NREQ` requesters. Each requester asks for a delay of `len` cycles; the block grants one request at a time, runs the shared counter from 0 up to `len`, and then reports completion with the winning requester's ID. It sits between independent timing clients and the one shared counter datapath, so no client needs a private counter.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `W`, 3: counter and length width in bits.

- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `req_val`  in  NREQ  request valid, one bit per requester.
- `req_rdy`  out  NREQ  request accepted; one-hot or zero.
- `req_len`  in  NREQ*W  packed lengths; requester i uses bits [i*W +: W].
- `done_val`  out  1  completion valid.
- `done_rdy`  in  1  completion consumer ready.
- `done_id`  out  $clog2(NREQ)  ID of the finished requester.
- `count`  out  W  shared counter value.
- `busy`  out  1  high in COUNT or DONE.

## Operation
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - If any `req_val` bit is set, the round-robin arbiter picks winner g and asserts `req_rdy[g]=1` combinationally in the same cycle.
  - On that edge the block latches `len_q=req_len[g]` and `id_q=g`, sets `count<=0`, and moves to COUNT.
  - `req_rdy` is 0 in every other state.
- COUNT:
  - If `count==len_q`, go to DONE and hold `count`.
  - Otherwise `count<=count+1` (mod 2^W).
  - `count` never wraps, because `len_q<=2^W-1`.
- DONE:
  - `done_val=1` and `done_id=id_q`.
  - On `done_val&&done_rdy`, go to IDLE and clear `count` to 0.
  - `count` holds `len_q` while stalled.
- Arbitration:
  - Priority pointer starts at requester 0.
  - After each grant, the pointer moves to g+1 (mod NREQ), so the last winner becomes lowest priority.
  - The pointer only changes on a grant.
- Boundary conditions:
  - `len=0`: exactly one COUNT cycle, with `count=0`.
  - `len=2^W-1`: counts 0..7 for W=3.
  - A requester that drops `req_val` while losing is simply not granted. This is legal; no protocol check is made.
- Reset, including mid-operation: state IDLE, `count=0`, pointer 0, `len_q=0`, `id_q=0`. All outputs are 0, and any in-flight request is discarded without a completion.

## Timing
- Accept at edge t, then COUNT for cycles t+1 .. t+1+len.
- `done_val` first rises in cycle t+2+len.
- With `done_rdy` tied high: the next grant can happen in cycle t+3+len, giving a throughput of one request per len+3 cycles.
- `count`, `done_val`, `done_id` and `busy` are registered or state-decoded only. `req_rdy` is combinational from `req_val`, the state, and the pointer.
- Simultaneous requests resolve in a single cycle; there is no extra arbitration latency.

## Configuration
- Macro: `SEQ_COUNT_SCHED_ABORT_EN`.
- Defined:
  - Adds input `abort` (1 bit).
  - `abort=1` in COUNT forces an early transition to DONE on the next edge, holding the current `count` value.
  - `abort` in IDLE or DONE is ignored.
  - Reset takes priority over `abort`.
- Undefined: the `abort` port does not exist, and COUNT only exits on `count==len_q`.

## Structure
- Package `seq_count_sched_pkg` holds:
  - state enum `sched_state_t` {IDLE, COUNT, DONE};
  - default constants `SCHED_NREQ=4` and `SCHED_W=3`.
- Sub-module `rr_arbiter` (parameter `NREQ`) holds the round-robin logic:
  - inputs: `clk`, `reset`, `req`, `en`;
  - output: one-hot `grant`;
  - the pointer updates when `en && |req`.
- The top level holds the FSM, the latches and the counter register.

## Test plan
- Reset, then `req_val=0001` with len0=3 → `req_rdy=0001` in cycle 0; `count` shows 0,1,2,3; `done_val=1`, `done_id=0` in cycle 5.
- `req_val=1111` held, all lens 0, `done_rdy=1` → grants in order 0,1,2,3,0, spaced 3 cycles apart.
- len=7 with W=3 → `count` reaches 7 with no wrap; `done_val` appears 9 cycles after accept.
- `done_rdy=0` for 4 cycles in DONE → `done_val` and `done_id` held stable, `count` held at len, and `req_rdy` stays 0 despite pending requests.
- Reset asserted mid-COUNT (`count=2`) → next cycle: IDLE, `count=0`, no `done_val`, and the next grant goes to requester 0.
- With `SEQ_COUNT_SCHED_ABORT_EN`: len=6, `abort` pulsed when `count=2` → DONE next cycle with `count=2` and the correct `done_id`.

Source files
------------

// File: rtl/seq_count_sched_pkg.sv
// Shared types and default sizing for the seq_count_sched slice.
package seq_count_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    localparam int SCHED_NREQ = 4;
    localparam int SCHED_W    = 3;

endpackage

// File: rtl/seq_count_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, rotating priority pointer that only moves on a grant.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] grant
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic [IW:0]   idx;
    logic          found;

    // Scan from the pointer upward, wrapping at NREQ; the first requester wins.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        idx   = '0;
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr} + (IW+1)'(i);
            if (idx >= (IW+1)'(NREQ))
                idx = idx - (IW+1)'(NREQ);
            if (!found && req[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
        if (en && found)
            grant[win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (en && found)
            ptr <= (win == IW'(NREQ-1)) ? '0 : win + 1'b1;
    end

endmodule

// File: rtl/seq_count_sched.sv
// Time-shares one up-counter among NREQ requesters with round-robin grants.
// Optional early-exit input `abort` when SEQ_COUNT_SCHED_ABORT_EN is defined.
module seq_count_sched
    import seq_count_sched_pkg::*;
#(
    parameter int NREQ = SCHED_NREQ,
    parameter int W    = SCHED_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_val,
    output logic [NREQ-1:0]         req_rdy,
    input  logic [NREQ*W-1:0]       req_len,
    output logic                    done_val,
    input  logic                    done_rdy,
    output logic [$clog2(NREQ)-1:0] done_id,
    output logic [W-1:0]            count,
    output logic                    busy
`ifdef SEQ_COUNT_SCHED_ABORT_EN
    ,
    input  logic                    abort
`endif
);

    localparam int IW = $clog2(NREQ);

    sched_state_t  state, state_nxt;
    logic [W-1:0]  count_q, len_q, gnt_len;
    logic [IW-1:0] id_q, gnt_id;
    logic [NREQ-1:0] grant;
    logic          accept;
    logic          abort_hit;
    logic          at_end;

`ifdef SEQ_COUNT_SCHED_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_val),
        .en    (state == IDLE),
        .grant (grant)
    );

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant[i])
                gnt_id = IW'(i);
    end

    assign gnt_len = req_len[gnt_id*W +: W];
    assign accept  = |grant;
    assign at_end  = (count_q == len_q) || abort_hit;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = COUNT;
            COUNT:   if (at_end)   state_nxt = DONE;
            DONE:    if (done_rdy) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Counter holds on exit from COUNT, so DONE shows the final (or aborted) value.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            len_q   <= '0;
            id_q    <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    len_q   <= gnt_len;
                    id_q    <= gnt_id;
                    count_q <= '0;
                end
                COUNT: if (!at_end)
                    count_q <= count_q + 1'b1;
                DONE: if (done_rdy)
                    count_q <= '0;
                default: count_q <= '0;
            endcase
        end
    end

    always_comb begin
        req_rdy  = (state == IDLE) ? grant : '0;
        done_val = (state == DONE);
        done_id  = id_q;
        count    = count_q;
        busy     = (state != IDLE);
    end

endmodule
